// File: rtl/pulpemu_ref_clk_ctrl.sv
// Runtime-programmable reference clock divider for the emulator. Divisor and
// enable changes are applied only at a period boundary, so ref_clk_o never glitches.
module pulpemu_ref_clk_ctrl #(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 256,
  parameter bit          START_EN    = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 cfg_req_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic                 cfg_en_i,
  output logic                 cfg_ack_o,
  output logic                 ref_clk_o,
  output logic                 ref_rise_o,
  output logic                 busy_o,
  output logic [DIV_WIDTH-1:0] div_o
);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PENDING = 2'd2
  } state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
  localparam state_e               ST_RST  = START_EN ? ST_RUNNING : ST_STOPPED;

  // Divisors below 2 cannot form a high and a low phase, so they saturate at 2.
  function automatic logic [DIV_WIDTH-1:0] sat_div(input logic [DIV_WIDTH-1:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] sh_div_q, sh_div_d;
  logic                 sh_en_q, sh_en_d;
  logic                 ack_q, ack_d;
  logic                 ref_q, ref_d;
  logic                 rise_q, rise_d;

  logic                 accept;
  logic                 at_end;
  logic [DIV_WIDTH-1:0] req_div;

  assign req_div = sat_div(cfg_div_i);
  // The ack cycle masks the still-asserted request so it is not taken twice.
  assign accept  = cfg_req_i && !ack_q && (state_q != ST_PENDING);
  assign at_end  = (cnt_q == (div_q - DIV_ONE));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    sh_div_d = sh_div_q;
    sh_en_d  = sh_en_q;
    ack_d    = 1'b0;

    unique case (state_q)
      ST_STOPPED: begin
        cnt_d = '0;
        if (accept) begin
          div_d   = req_div;
          ack_d   = 1'b1;
          state_d = cfg_en_i ? ST_RUNNING : ST_STOPPED;
        end
      end
      ST_RUNNING: begin
        cnt_d = at_end ? '0 : (cnt_q + DIV_ONE);
        if (accept) begin
          if (at_end) begin
            div_d   = req_div;
            ack_d   = 1'b1;
            state_d = cfg_en_i ? ST_RUNNING : ST_STOPPED;
          end else begin
            sh_div_d = req_div;
            sh_en_d  = cfg_en_i;
            state_d  = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        cnt_d = at_end ? '0 : (cnt_q + DIV_ONE);
        if (at_end) begin
          div_d   = sh_div_q;
          ack_d   = 1'b1;
          state_d = sh_en_q ? ST_RUNNING : ST_STOPPED;
        end
      end
      default: begin
        state_d = ST_RST;
        cnt_d   = '0;
      end
    endcase

    // Output flop is fed from next-state values so it tracks the counter exactly.
    ref_d  = (state_d != ST_STOPPED) && (cnt_d >= (div_d >> 1));
    rise_d = ref_d && !ref_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      div_q   <= DIV_RST;
      ack_q   <= 1'b0;
      ref_q   <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      ack_q   <= ack_d;
      ref_q   <= ref_d;
      rise_q  <= rise_d;
    end
  end

  // Shadow values are only consumed from PENDING, which is always entered after a load.
  always_ff @(posedge clk_i) begin
    sh_div_q <= sh_div_d;
    sh_en_q  <= sh_en_d;
  end

  assign cfg_ack_o  = ack_q;
  assign ref_clk_o  = ref_q;
  assign ref_rise_o = rise_q;
  assign busy_o     = (state_q == ST_PENDING);
  assign div_o      = div_q;

endmodule

// File: tb/tb_pulpemu_ref_clk_ctrl.sv
// Directed bench for pulpemu_ref_clk_ctrl: defaults, boundary-timed reconfiguration,
// disable/re-enable, divisor clamping and reset while a request is pending.
module tb_pulpemu_ref_clk_ctrl;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        cfg_req_i;
  logic [15:0] cfg_div_i;
  logic        cfg_en_i;
  logic        cfg_ack_o;
  logic        ref_clk_o;
  logic        ref_rise_o;
  logic        busy_o;
  logic [15:0] div_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt      = 0;

  pulpemu_ref_clk_ctrl #(
    .DIV_WIDTH  (16),
    .DEFAULT_DIV(256),
    .START_EN   (1'b1)
  ) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .cfg_req_i (cfg_req_i),
    .cfg_div_i (cfg_div_i),
    .cfg_en_i  (cfg_en_i),
    .cfg_ack_o (cfg_ack_o),
    .ref_clk_o (ref_clk_o),
    .ref_rise_o(ref_rise_o),
    .busy_o    (busy_o),
    .div_o     (div_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Checks n cycles of free-running output for divisor div, starting at bench counter cnt.
  task automatic expect_ref(input int n, input int div, input logic exp_busy);
    for (int i = 0; i < n; i++) begin
      chk("ref", 32'(ref_clk_o), 32'(cnt >= div / 2));
      chk("rise", 32'(ref_rise_o), 32'(cnt == div / 2));
      chk("busy", 32'(busy_o), 32'(exp_busy));
      chk("no_ack", 32'(cfg_ack_o), 32'd0);
      chk("div_o", 32'(div_o), 32'(div));
      tick();
      cnt = (cnt + 1) % div;
    end
  endtask

  // Ticks until ack (bounded); leaves the bench in the cycle after ack with req dropped.
  task automatic wait_ack(input int max_cycles, input int exp_div);
    int k;
    k = 0;
    tick();
    while (cfg_ack_o !== 1'b1 && k < max_cycles) begin
      tick();
      k++;
    end
    chk("ack_seen", 32'(cfg_ack_o), 32'd1);
    chk("ack_div", 32'(div_o), 32'(exp_div));
    chk("ack_ref", 32'(ref_clk_o), 32'd0);
    tick();
    cfg_req_i = 1'b0;
    cnt = 1;
  endtask

  task automatic request(input int div, input logic en);
    cfg_req_i = 1'b1;
    cfg_div_i = 16'(div);
    cfg_en_i  = en;
  endtask

  initial begin
    rstn_i    = 1'b0;
    cfg_req_i = 1'b0;
    cfg_div_i = '0;
    cfg_en_i  = 1'b0;
    repeat (3) tick();
    chk("rst_ack", 32'(cfg_ack_o), 32'd0);
    chk("rst_ref", 32'(ref_clk_o), 32'd0);
    chk("rst_rise", 32'(ref_rise_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_div", 32'(div_o), 32'd256);
    rstn_i = 1'b1;
    cnt = 0;

    // Default period: 128 low, 128 high, rise at counter 128.
    expect_ref(256, 256, 1'b0);

    // Divisor 10 requested mid-period at counter 50.
    expect_ref(50, 256, 1'b0);
    request(10, 1'b1);
    expect_ref(1, 256, 1'b0);
    expect_ref(205, 256, 1'b1);
    chk("s2_ack", 32'(cfg_ack_o), 32'd1);
    chk("s2_div", 32'(div_o), 32'd10);
    chk("s2_busy", 32'(busy_o), 32'd0);
    chk("s2_ref", 32'(ref_clk_o), 32'd0);
    tick();
    cfg_req_i = 1'b0;
    cnt = 1;
    expect_ref(19, 10, 1'b0);

    // Same-edge request at the last counter value: no busy cycle.
    expect_ref(9, 10, 1'b0);
    request(7, 1'b1);
    expect_ref(1, 10, 1'b0);
    chk("s3_ack", 32'(cfg_ack_o), 32'd1);
    chk("s3_busy", 32'(busy_o), 32'd0);
    chk("s3_div", 32'(div_o), 32'd7);
    chk("s3_ref", 32'(ref_clk_o), 32'd0);
    tick();
    cfg_req_i = 1'b0;
    cnt = 1;
    expect_ref(13, 7, 1'b0);

    // Disable in the high phase; period completes, then stops.
    expect_ref(4, 7, 1'b0);
    request(7, 1'b0);
    expect_ref(1, 7, 1'b0);
    expect_ref(2, 7, 1'b1);
    chk("s4_ack", 32'(cfg_ack_o), 32'd1);
    chk("s4_ref", 32'(ref_clk_o), 32'd0);
    chk("s4_busy", 32'(busy_o), 32'd0);
    tick();
    cfg_req_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stop_ref", 32'(ref_clk_o), 32'd0);
      chk("stop_rise", 32'(ref_rise_o), 32'd0);
      chk("stop_ack", 32'(cfg_ack_o), 32'd0);
      tick();
    end

    // Re-enable from STOPPED with divisor 4: ack next cycle, then 0,0,1,1.
    request(4, 1'b1);
    tick();
    chk("s4e_ack", 32'(cfg_ack_o), 32'd1);
    chk("s4e_div", 32'(div_o), 32'd4);
    chk("s4e_ref", 32'(ref_clk_o), 32'd0);
    tick();
    cfg_req_i = 1'b0;
    cnt = 1;
    expect_ref(7, 4, 1'b0);

    // Divisor 0 and 1 clamp to 2.
    request(0, 1'b1);
    wait_ack(20, 2);
    expect_ref(8, 2, 1'b0);
    request(1, 1'b1);
    wait_ack(20, 2);
    expect_ref(8, 2, 1'b0);

    // Reset while PENDING: no ack, back to defaults.
    expect_ref(1, 2, 1'b0);
    request(9, 1'b1);
    tick();
    chk("s6_busy", 32'(busy_o), 32'd1);
    rstn_i = 1'b0;
    #1;
    chk("s6_rst_busy", 32'(busy_o), 32'd0);
    chk("s6_rst_ref", 32'(ref_clk_o), 32'd0);
    chk("s6_rst_div", 32'(div_o), 32'd256);
    cfg_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s6_rst_ack", 32'(cfg_ack_o), 32'd0);
      chk("s6_rst_rise", 32'(ref_rise_o), 32'd0);
    end
    rstn_i = 1'b1;
    cnt = 0;
    expect_ref(256, 256, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/pulpemu_ref_clk_ctrl.md
Name: pulpemu_ref_clk_ctrl

Overview:
- Runtime-programmable controller and generator for the emulator's reference clock (nominally 32768 Hz from 8.388608 MHz, DIV=256).
- Lets the SoC control/debug logic change the divisor and enable/disable the reference clock through a req/ack handshake.
- Changes take effect only at a period boundary, so ref_clk_o never produces a runt pulse or glitch.
- Sits between the emulation clock source and the SoC ref_clk input.

Parameters:
- DIV_WIDTH, 16, width of divisor and internal counter.
- DEFAULT_DIV, 256, divisor loaded at reset.
- START_EN, 1, 1 = reference clock runs out of reset; 0 = stopped out of reset.

Ports:
- clk_i  in  1  emulation clock.
- rstn_i  in  1  asynchronous active-low reset.
- cfg_req_i  in  1  configuration request; held high with stable data until ack.
- cfg_div_i  in  DIV_WIDTH  requested divisor.
- cfg_en_i  in  1  requested enable.
- cfg_ack_o  out  1  one-cycle pulse: configuration applied.
- ref_clk_o  out  1  divided reference clock, flop-driven.
- ref_rise_o  out  1  one-cycle pulse in the cycle ref_clk_o goes 0->1.
- busy_o  out  1  request captured, waiting for period boundary.
- div_o  out  DIV_WIDTH  divisor currently in effect.

Behaviour:
- Reset values:
  - counter=0, div_q=DEFAULT_DIV, state=RUNNING if START_EN else STOPPED.
  - cfg_ack_o=0, ref_clk_o=0, ref_rise_o=0, busy_o=0, div_o=DEFAULT_DIV.
- Clamping: divisor values 0 and 1 are clamped to 2 on capture. div_o always reports the clamped value.
- States: STOPPED, RUNNING, PENDING. busy_o=1 only in PENDING.
- Counting (RUNNING and PENDING):
  - counter increments each cycle.
  - At counter==div_q-1, next counter is 0.
- Output invariant: ref_clk_o == (state!=STOPPED && counter >= div_q>>1) in every cycle. It is registered from next-state values, so there is no combinational path to the output.
  - Low phase = floor(div/2) cycles; high phase = ceil(div/2) cycles.
  - Example: div=5 gives 2 low, 3 high.
- STOPPED: counter held at 0, ref_clk_o=0.
- Request acceptance:
  - A request is accepted when cfg_req_i=1, cfg_ack_o=0 and state!=PENDING.
  - The requester drops cfg_req_i in the cycle after ack. cfg_req_i seen during the ack cycle is ignored.
- Accepted in STOPPED (cycle t):
  - At the t edge: div_q/en take the new values.
  - State becomes RUNNING if en, else stays STOPPED.
  - cfg_ack_o=1 in cycle t+1. Counter is 0 in t+1 (ref low); first increment at the end of t+1.
- Accepted in RUNNING with counter != div_q-1: values go into a shadow register and state becomes PENDING.
- Accepted in RUNNING with counter == div_q-1: applied at that same edge, as at a boundary (no PENDING).
- Boundary (counter==div_q-1 while PENDING, or the same-edge case above):
  - Next cycle: counter=0, div_q=shadow, cfg_ack_o=1.
  - State becomes RUNNING if en, else STOPPED with ref_clk_o=0.
  - The last period with the old divisor always completes in full.
- Re-request of the same values is legal and acks through the same boundary path.
- Reset asserted mid-operation: immediate return to reset values. Any pending shadow request is discarded and no ack is issued.
- Width rules:
  - Counter is DIV_WIDTH bits; compare against div_q-1 (never overflows, since div_q>=2).
  - div_q>>1 is a logical shift.

Test Plan:
- Reset release, defaults (256, START_EN=1): ref_clk_o low for counter 0..127, high for 128..255, period 256 cycles; first ref_rise_o at counter 128.
- In RUNNING, div=256, request div=10 at counter 50:
  - busy_o=1 until counter 255.
  - Then counter=0, cfg_ack_o=1, div_o=10.
  - After that: 5 low / 5 high.
- Request at counter==255 (div=256), div=7: no busy cycle; ack next cycle with counter 0; then 3 low / 4 high.
- Disable (en=0) while high phase:
  - ref stays high until counter 255, then ack with ref low.
  - Counter frozen at 0.
  - Re-enable with div=4 from STOPPED: ack next cycle, then pattern 0,0,1,1.
- cfg_div_i=0 and =1 -> div_o=2, ref_clk_o toggles every cycle; ref_rise_o every other cycle.
- Assert rstn_i while PENDING -> outputs return to reset values, no ack ever issued; after release, period 256 again.
